// File: rtl/fc_mac_layer.sv
// fc_mac_layer: one fully-connected layer engine.
// Holds an input vector x[IN_CELL] and a weight matrix w[OUT_CELL][IN_CELL]. Both are loaded
// through the external write bus. On start it computes OUT_CELL signed fixed-point dot
// products, one MAC per cycle. Each result is streamed out with optional ReLU and saturation.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   ex_we/ex_sel        write enable; buffer select (0 = input, 1 = weight)
//   ex_addr/ex_value    word address within the selected buffer; signed write data
//   start, relu_en      run request; ReLU mode, sampled together with start
//   busy                computation in progress (writes and start are ignored while set)
//   out_valid           out_addr/out_value hold a fresh result this cycle
//   out_addr/out_value  output neuron index and its saturated result
//   done                one-cycle pulse when the layer has finished
module fc_mac_layer #(
  parameter int unsigned IN_CELL  = 14,
  parameter int unsigned OUT_CELL = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 10,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned ADDR_W   = 16,
  localparam int unsigned OUT_AW  = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ex_we,
  input  logic                     ex_sel,
  input  logic [ADDR_W-1:0]        ex_addr,
  input  logic signed [DATA_W-1:0] ex_value,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     out_valid,
  output logic [OUT_AW-1:0]        out_addr,
  output logic signed [DATA_W-1:0] out_value,
  output logic                     done
);

  localparam int unsigned IW      = (IN_CELL > 1) ? $clog2(IN_CELL) : 1;
  localparam int unsigned W_DEPTH = IN_CELL * OUT_CELL;
  localparam int unsigned WW      = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} state_e;

  state_e                     state_q;
  logic [IW-1:0]              i_q;
  logic [OUT_AW-1:0]          o_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       relu_q;

  // Buffers are plain register arrays with no reset: contents survive reset.
  logic signed [DATA_W-1:0]   x_mem [IN_CELL];
  logic signed [DATA_W-1:0]   w_mem [W_DEPTH];

  logic [WW-1:0]              w_idx;
  logic signed [DATA_W-1:0]   x_rd, w_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, shifted, clipped;
  logic signed [DATA_W-1:0]   result;

  always_ff @(posedge clk) begin
    if (ex_we && !busy) begin
      if (!ex_sel && (32'(ex_addr) < IN_CELL)) begin
        x_mem[IW'(ex_addr)] <= ex_value;
      end
      if (ex_sel && (32'(ex_addr) < W_DEPTH)) begin
        w_mem[WW'(ex_addr)] <= ex_value;
      end
    end
  end

  always_comb begin
    w_idx    = WW'(32'(o_q) * IN_CELL + 32'(i_q));
    x_rd     = x_mem[i_q];
    w_rd     = w_mem[w_idx];
    prod     = x_rd * w_rd;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // Arithmetic shift floors toward -inf.
    shifted  = acc_q >>> FRAC_W;
    clipped  = shifted;
    if (relu_q && shifted[ACC_W-1]) begin
      clipped = '0;
    end else if (shifted > SatMax) begin
      clipped = SatMax;
    end else if (shifted < SatMin) begin
      clipped = SatMin;
    end
    result   = DATA_W'(clipped);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      i_q       <= '0;
      o_q       <= '0;
      acc_q     <= '0;
      relu_q    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_value <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            relu_q  <= relu_en;
            o_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            busy    <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          if (i_q == IW'(IN_CELL - 1)) begin
            state_q <= StEmit;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        StEmit: begin
          out_value <= result;
          out_addr  <= o_q;
          out_valid <= 1'b1;
          acc_q     <= '0;
          i_q       <= '0;
          if (o_q == OUT_AW'(OUT_CELL - 1)) begin
            state_q <= StDone;
          end else begin
            o_q     <= o_q + OUT_AW'(1);
            state_q <= StMac;
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_layer.sv
// Bench for fc_mac_layer: a 4x3 instance (directed table, protocol, random, reset abort) and
// a default-sized 14x10 instance (patterned data against the reference model).
module tb_fc_mac_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, ex_sel, relu_en;
  logic [15:0]        ex_addr;
  logic signed [15:0] ex_value;
  logic               s_we, s_start, d_we, d_start;
  logic               s_busy, s_ov, s_done, d_busy, d_ov, d_done;
  logic [1:0]         s_oaddr;
  logic [3:0]         d_oaddr;
  logic signed [15:0] s_oval, d_oval;

  int checks = 0;
  int errors = 0;
  int sx[4];
  int sw[12];
  int dx[14];
  int dw[140];

  fc_mac_layer #(.IN_CELL(4), .OUT_CELL(3)) u_small (
    .clk(clk), .reset_n(reset_n), .ex_we(s_we), .ex_sel(ex_sel), .ex_addr(ex_addr),
    .ex_value(ex_value), .start(s_start), .relu_en(relu_en), .busy(s_busy),
    .out_valid(s_ov), .out_addr(s_oaddr), .out_value(s_oval), .done(s_done)
  );

  fc_mac_layer u_def (
    .clk(clk), .reset_n(reset_n), .ex_we(d_we), .ex_sel(ex_sel), .ex_addr(ex_addr),
    .ex_value(ex_value), .start(d_start), .relu_en(relu_en), .busy(d_busy),
    .out_valid(d_ov), .out_addr(d_oaddr), .out_value(d_oval), .done(d_done)
  );

  typedef struct packed {
    logic [3:0][31:0] x;    // input vector
    logic [2:0][31:0] w;    // one uniform weight per row
    logic             relu;
    logic [2:0][31:0] e;    // expected outputs
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(int x0, int x1, int x2, int x3, int w0, int w1, int w2,
                              bit r, int e0, int e1, int e2);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.relu = r;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Dot product, floor division by 2^10, optional ReLU, clamp to 16-bit signed.
  function automatic int ref_out(bit dut, int o, bit relu);
    longint sum = 0;
    longint q;
    if (dut) begin
      for (int i = 0; i < 14; i++) sum += longint'(dx[i]) * longint'(dw[o*14+i]);
    end else begin
      for (int i = 0; i < 4; i++) sum += longint'(sx[i]) * longint'(sw[o*4+i]);
    end
    q = sum / 1024;
    if (sum < 0 && q * 1024 != sum) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic wr(input bit dut, input bit sel, input int addr, input int val);
    @(negedge clk);
    s_we     = !dut;
    d_we     = dut;
    ex_sel   = sel;
    ex_addr  = 16'(addr);
    ex_value = 16'(val);
  endtask

  task automatic wr_end();
    @(negedge clk);
    s_we = 1'b0;
    d_we = 1'b0;
  endtask

  task automatic load_small(input int xv[4], input int wv[12]);
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 1'b0, i, xv[i]);
      sx[i] = xv[i];
    end
    for (int k = 0; k < 12; k++) begin
      wr(1'b0, 1'b1, k, wv[k]);
      sw[k] = wv[k];
    end
    wr_end();
  endtask

  // Starts a run, then follows it cycle by cycle (sampled on negedge) within a fixed budget.
  task automatic run_layer(input bit dut, input bit relu, input bit disturb, input int want[10],
                           input string tag);
    int n_in, n_out, e, k, dones, oa, ov_val;
    bit ov, dn;
    n_in  = dut ? 14 : 4;
    n_out = dut ? 10 : 3;
    @(negedge clk);
    relu_en = relu;
    if (dut) d_start = 1'b1;
    else     s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    d_start = 1'b0;
    e = 0; k = 0; dones = 0;
    check({tag, " busy_after_start"}, dut ? d_busy : s_busy, 1);
    while (e < n_out * (n_in + 1) + 4) begin
      @(negedge clk);
      e++;
      ov     = dut ? d_ov : s_ov;
      dn     = dut ? d_done : s_done;
      oa     = dut ? int'(d_oaddr) : int'(s_oaddr);
      ov_val = dut ? int'(d_oval) : int'(s_oval);
      if (ov) begin
        if (k < n_out) begin
          check($sformatf("%s out_addr[%0d]", tag, k), oa, k);
          check($sformatf("%s out_value[%0d]", tag, k), ov_val, want[k]);
          check($sformatf("%s valid_cycle[%0d]", tag, k), e, (k + 1) * (n_in + 1));
        end
        k++;
      end
      if (dn) begin
        check({tag, " done_cycle"}, e, n_out * (n_in + 1) + 1);
        dones++;
      end
      if (disturb) begin
        // Writes, extra starts and a relu_en flip while busy must all be ignored.
        case (e)
          3: begin
            s_we = 1'b1; ex_sel = 1'b0; ex_addr = 16'd0; ex_value = 16'sd999;
            s_start = 1'b1; relu_en = !relu;
          end
          4: begin
            ex_sel = 1'b1; ex_addr = 16'd5; ex_value = -16'sd7; s_start = 1'b0;
          end
          5:  s_we = 1'b0;
          12: s_start = 1'b1;
          13: s_start = 1'b0;
          15: s_start = 1'b1;
          16: s_start = 1'b0;
          default: ;
        endcase
      end
    end
    check({tag, " result_count"}, k, n_out);
    check({tag, " done_count"}, dones, 1);
    check({tag, " busy_at_end"}, dut ? d_busy : s_busy, 0);
  endtask

  initial begin
    int xv[4];
    int wv[12];
    int want[10];
    int lo, hi;
    bit rr;

    reset_n = 1'b0; ex_sel = 1'b0; ex_addr = '0; ex_value = '0; relu_en = 1'b0;
    s_we = 1'b0; s_start = 1'b0; d_we = 1'b0; d_start = 1'b0;
    for (int i = 0; i < 10; i++) want[i] = 0;
    repeat (3) @(negedge clk);
    check("rst busy", s_busy, 0);
    check("rst out_valid", s_ov, 0);
    check("rst out_addr", s_oaddr, 0);
    check("rst out_value", s_oval, 0);
    check("rst done", s_done, 0);
    check("rst def busy", d_busy, 0);
    reset_n = 1'b1;

    tbl[0] = mk(1024, 2048, 3072, 4096, 1024, -1024, 32767, 1'b0, 10240, -10240, 32767);
    tbl[1] = mk(1024, 2048, 3072, 4096, 1024, -1024, 32767, 1'b1, 10240, 0, 32767);
    tbl[2] = mk(1, 0, 0, 0, -1, -1, -1, 1'b0, -1, -1, -1);
    tbl[3] = mk(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 1'b0,
                -32768, -32768, -32768);
    tbl[4] = mk(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 1'b1, 0, 0, 0);
    tbl[5] = mk(3, -5, 7, 0, 1024, -512, -100, 1'b0, 5, -3, -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) xv[i] = int'(tbl[t].x[i]);
      for (int k = 0; k < 12; k++) wv[k] = int'(tbl[t].w[k / 4]);
      for (int k = 0; k < 3; k++) want[k] = int'(tbl[t].e[k]);
      load_small(xv, wv);
      run_layer(1'b0, tbl[t].relu, 1'b0, want, $sformatf("vec%0d", t));
    end

    // Protocol: out-of-range writes dropped, busy-time writes/starts ignored.
    for (int i = 0; i < 4; i++) xv[i] = int'(tbl[0].x[i]);
    for (int k = 0; k < 12; k++) wv[k] = int'(tbl[0].w[k / 4]);
    for (int k = 0; k < 3; k++) want[k] = int'(tbl[0].e[k]);
    load_small(xv, wv);
    wr(1'b0, 1'b0, 4, 7777);
    wr(1'b0, 1'b1, 12, 5555);
    wr_end();
    run_layer(1'b0, 1'b0, 1'b1, want, "proto_busy");
    run_layer(1'b0, 1'b0, 1'b0, want, "proto_clean");

    // Random data against the reference model; alternate full and small ranges.
    for (int r = 0; r < 6; r++) begin
      lo = (r % 2 == 0) ? -32768 : -300;
      hi = (r % 2 == 0) ? 32767 : 300;
      for (int i = 0; i < 4; i++) xv[i] = lo + int'($urandom_range(32'(hi - lo), 0));
      for (int k = 0; k < 12; k++) wv[k] = lo + int'($urandom_range(32'(hi - lo), 0));
      rr = 1'($urandom % 2);
      load_small(xv, wv);
      for (int k = 0; k < 3; k++) want[k] = ref_out(1'b0, k, rr);
      run_layer(1'b0, rr, 1'b0, want, $sformatf("rand%0d", r));
    end

    // Default-sized instance.
    for (int i = 0; i < 14; i++) begin
      wr(1'b1, 1'b0, i, 10 + 10 * i);
      dx[i] = 10 + 10 * i;
    end
    for (int k = 0; k < 140; k++) begin
      wr(1'b1, 1'b1, k, -250 + 3 * k);
      dw[k] = -250 + 3 * k;
    end
    wr_end();
    for (int k = 0; k < 10; k++) want[k] = ref_out(1'b1, k, 1'b0);
    run_layer(1'b1, 1'b0, 1'b0, want, "defaults");

    // Reset abort after edge 7, then a full rerun from the retained buffers.
    for (int k = 0; k < 3; k++) want[k] = int'(tbl[0].e[k]);
    load_small(xv, wv);
    for (int i = 0; i < 4; i++) xv[i] = int'(tbl[0].x[i]);
    for (int k = 0; k < 12; k++) wv[k] = int'(tbl[0].w[k / 4]);
    load_small(xv, wv);
    @(negedge clk);
    relu_en = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort busy_before", s_busy, 1);
    check("abort out_value_before", s_oval, 10240);
    reset_n = 1'b0;
    #1;
    check("abort busy", s_busy, 0);
    check("abort out_valid", s_ov, 0);
    check("abort done", s_done, 0);
    check("abort out_value", s_oval, 0);
    check("abort out_addr", s_oaddr, 0);
    @(negedge clk);
    check("abort no_done", s_done, 0);
    reset_n = 1'b1;
    run_layer(1'b0, 1'b0, 1'b0, want, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
